// File: rtl/goruntu_besleyici_if.sv
// Host/core side signal bundle for the frame feeder.
// Signal names mirror the feeder's own port list.
interface goruntu_besleyici_if #(
    parameter int IND_W = 17
);
    logic             yaz_en_i;
    logic [7:0]       yaz_veri_i;
    logic             basla_i;
    logic [7:0]       veri_o;
    logic             veri_gecerli_o;
    logic             veri_al_i;
    logic [7:0]       veri_i;
    logic             veri_gonder_i;
    logic             oku_en_i;
    logic [7:0]       oku_veri_o;
    logic             oku_gecerli_o;
    logic             islem_bitti_o;
    logic [2:0]       durum_o;
    logic [IND_W-1:0] indis_o;

    modport slave (
        input  yaz_en_i, yaz_veri_i, basla_i,
        input  veri_al_i, veri_i, veri_gonder_i, oku_en_i,
        output veri_o, veri_gecerli_o, oku_veri_o, oku_gecerli_o,
        output islem_bitti_o, durum_o, indis_o
    );

    modport master (
        output yaz_en_i, yaz_veri_i, basla_i,
        output veri_al_i, veri_i, veri_gonder_i, oku_en_i,
        input  veri_o, veri_gecerli_o, oku_veri_o, oku_gecerli_o,
        input  islem_bitti_o, durum_o, indis_o
    );
endinterface

// File: rtl/goruntu_besleyici.sv
// Frame buffer feeding pixels to the gray2bw/erozyon core and
// capturing its processed stream for host readback.
module goruntu_besleyici #(
    parameter int PIKSEL_SAYISI = 76800,
    parameter int IND_W         = 17
) (
    input  logic               clk_i,
    input  logic               rst_i,
    goruntu_besleyici_if.slave bus
);
    localparam int AW = (PIKSEL_SAYISI > 1) ? $clog2(PIKSEL_SAYISI) : 1;
    localparam logic [IND_W-1:0] SON   = IND_W'(PIKSEL_SAYISI);
    localparam logic [IND_W-1:0] SON_1 = IND_W'(PIKSEL_SAYISI - 1);

    typedef enum logic [2:0] {
        BOS        = 3'd0,
        GONDER_OKU = 3'd1,
        GONDER_SUN = 3'd2,
        AL         = 3'd3,
        BITTI      = 3'd4
    } durum_t;

    durum_t           r_durum, w_durum_n;
    logic [IND_W-1:0] r_indis, w_indis_n;
    logic [IND_W-1:0] r_okuma, w_okuma_n;
    logic             r_gecerli, w_gecerli_n;
    logic             r_bitti, w_bitti_n;
    logic             r_oku_gecerli;
    logic [7:0]       r_veri;
    logic [7:0]       r_oku_son;
    logic [7:0]       r_mem [PIKSEL_SAYISI];
    logic [7:0]       r_rd;
    logic             w_we, w_re, w_oku;
    logic [IND_W-1:0] w_adr;
    logic [7:0]       w_wd;

    always_comb begin
        w_durum_n   = r_durum;
        w_indis_n   = r_indis;
        w_okuma_n   = r_okuma;
        w_gecerli_n = r_gecerli;
        w_bitti_n   = r_bitti;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_oku       = 1'b0;
        w_adr       = r_indis;
        w_wd        = bus.yaz_veri_i;
        unique case (r_durum)
            BOS: begin
                if (bus.yaz_en_i) begin
                    if (r_indis != SON) begin
                        w_we      = 1'b1;
                        w_indis_n = r_indis + 1'b1;
                    end
                end else if (bus.basla_i && r_indis == SON) begin
                    w_indis_n = '0;
                    w_durum_n = GONDER_OKU;
                end
            end
            GONDER_OKU: begin
                w_re      = 1'b1;
                w_durum_n = GONDER_SUN;
            end
            GONDER_SUN: begin
                // valid low here means read data has just arrived
                if (!r_gecerli) begin
                    w_gecerli_n = 1'b1;
                end else if (bus.veri_al_i) begin
                    w_gecerli_n = 1'b0;
                    if (r_indis == SON_1) begin
                        w_indis_n = '0;
                        w_durum_n = AL;
                    end else begin
                        w_indis_n = r_indis + 1'b1;
                        w_durum_n = GONDER_OKU;
                    end
                end
            end
            AL: begin
                if (bus.veri_gonder_i) begin
                    w_we = 1'b1;
                    w_wd = bus.veri_i;
                    if (r_indis == SON_1) begin
                        w_indis_n = '0;
                        w_bitti_n = 1'b1;
                        w_durum_n = BITTI;
                    end else begin
                        w_indis_n = r_indis + 1'b1;
                    end
                end
            end
            BITTI: begin
                // leave only once the last readback pulse is on the bus
                if (r_oku_gecerli && r_okuma == SON) begin
                    w_okuma_n = '0;
                    w_indis_n = '0;
                    w_bitti_n = 1'b0;
                    w_durum_n = BOS;
                end else if (bus.oku_en_i && r_okuma != SON) begin
                    w_oku     = 1'b1;
                    w_re      = 1'b1;
                    w_adr     = r_okuma;
                    w_okuma_n = r_okuma + 1'b1;
                end
            end
            default: w_durum_n = BOS;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_durum <= BOS;
        end else begin
            r_durum <= w_durum_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_indis       <= '0;
            r_okuma       <= '0;
            r_gecerli     <= 1'b0;
            r_bitti       <= 1'b0;
            r_oku_gecerli <= 1'b0;
            r_veri        <= '0;
            r_oku_son     <= '0;
        end else begin
            r_indis       <= w_indis_n;
            r_okuma       <= w_okuma_n;
            r_gecerli     <= w_gecerli_n;
            r_bitti       <= w_bitti_n;
            r_oku_gecerli <= w_oku;
            if (r_durum == GONDER_SUN && !r_gecerli) begin
                r_veri <= r_rd;
            end
            if (r_oku_gecerli) begin
                r_oku_son <= r_rd;
            end
        end
    end

    // single-port buffer, contents survive reset
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[w_adr[AW-1:0]] <= w_wd;
        end
        if (w_re) begin
            r_rd <= r_mem[w_adr[AW-1:0]];
        end
    end

    assign bus.veri_o         = r_veri;
    assign bus.veri_gecerli_o = r_gecerli;
    assign bus.oku_veri_o     = r_oku_gecerli ? r_rd : r_oku_son;
    assign bus.oku_gecerli_o  = r_oku_gecerli;
    assign bus.islem_bitti_o  = r_bitti;
    assign bus.durum_o        = r_durum;
    assign bus.indis_o        = r_indis;
endmodule

// File: tb/tb_goruntu_besleyici.sv
// Scoreboard bench for goruntu_besleyici with a 16-pixel frame.
module tb_goruntu_besleyici;
    localparam int N = 16;
    localparam int W = 17;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    logic [7:0] q_sun [$];
    logic [7:0] q_oku [$];
    logic [7:0] son_sun = '0;
    logic [7:0] son_oku = '0;
    logic       p_gec = 1'b0;

    goruntu_besleyici_if #(.IND_W(W)) bus ();

    goruntu_besleyici #(
        .PIKSEL_SAYISI(N),
        .IND_W        (W)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic adim();
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            p_gec   = 1'b0;
            son_sun = '0;
            son_oku = '0;
        end else begin
            if (bus.veri_gecerli_o && !p_gec) begin
                if (q_sun.size() == 0) begin
                    chk("sun_fazla", 32'(q_sun.size()), 1);
                end else begin
                    son_sun = q_sun.pop_front();
                    chk("sun_veri", 32'(bus.veri_o), 32'(son_sun));
                end
            end else if (bus.veri_gecerli_o) begin
                chk("sun_sabit", 32'(bus.veri_o), 32'(son_sun));
            end else begin
                chk("sun_tut", 32'(bus.veri_o), 32'(son_sun));
            end
            p_gec = bus.veri_gecerli_o;
            if (bus.oku_gecerli_o) begin
                if (q_oku.size() == 0) begin
                    chk("oku_fazla", 32'(q_oku.size()), 1);
                end else begin
                    son_oku = q_oku.pop_front();
                    chk("oku_veri", 32'(bus.oku_veri_o), 32'(son_oku));
                end
            end else begin
                chk("oku_tut", 32'(bus.oku_veri_o), 32'(son_oku));
            end
        end
    end

    task automatic yukle(int n, int taban, bit it);
        for (int i = 0; i < n; i++) begin
            bus.yaz_en_i   = 1'b1;
            bus.yaz_veri_i = 8'(taban + i);
            if (it && i < N) q_sun.push_back(8'(taban + i));
            adim();
        end
        bus.yaz_en_i = 1'b0;
    endtask

    task automatic basla();
        bus.basla_i = 1'b1;
        adim();
        bus.basla_i = 1'b0;
    endtask

    task automatic cekirdek_al(int n, int gecikme);
        for (int p = 0; p < n; p++) begin
            int t = 0;
            while (!bus.veri_gecerli_o && t < 20) begin
                adim();
                t++;
            end
            chk("sun_zaman", 32'(bus.veri_gecerli_o), 1);
            repeat (gecikme) adim();
            bus.veri_al_i = 1'b1;
            adim();
            bus.veri_al_i = 1'b0;
            chk("sun_dus", 32'(bus.veri_gecerli_o), 0);
        end
    endtask

    task automatic yakala(int taban);
        for (int k = 0; k < N; k++) begin
            bus.veri_gonder_i = 1'b1;
            bus.veri_i        = 8'(taban - k);
            q_oku.push_back(8'(taban - k));
            adim();
            if (k == N - 2) chk("bitti_erken", 32'(bus.islem_bitti_o), 0);
        end
        bus.veri_gonder_i = 1'b0;
        chk("bitti", 32'(bus.islem_bitti_o), 1);
        chk("durum_bitti", 32'(bus.durum_o), 4);
    endtask

    task automatic geri_oku();
        for (int k = 0; k < N; k++) begin
            bus.oku_en_i = 1'b1;
            adim();
            chk("oku_darbe", 32'(bus.oku_gecerli_o), 1);
            bus.oku_en_i = 1'b0;
            adim();
            chk("oku_dus", 32'(bus.oku_gecerli_o), 0);
        end
        chk("durum_bos", 32'(bus.durum_o), 0);
        chk("bitti_dus", 32'(bus.islem_bitti_o), 0);
        chk("indis_bos", 32'(bus.indis_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.yaz_en_i      = 1'b0;
        bus.yaz_veri_i    = '0;
        bus.basla_i       = 1'b0;
        bus.veri_al_i     = 1'b0;
        bus.veri_i        = '0;
        bus.veri_gonder_i = 1'b0;
        bus.oku_en_i      = 1'b0;
        repeat (3) adim();
        chk("rst_durum", 32'(bus.durum_o), 0);
        chk("rst_indis", 32'(bus.indis_o), 0);
        chk("rst_gec", 32'(bus.veri_gecerli_o), 0);
        chk("rst_veri", 32'(bus.veri_o), 0);
        chk("rst_oku", 32'(bus.oku_gecerli_o), 0);
        chk("rst_okuv", 32'(bus.oku_veri_o), 0);
        chk("rst_bitti", 32'(bus.islem_bitti_o), 0);
        rst_i = 1'b1;
        adim();

        // normal frame
        yukle(N, 0, 1);
        chk("yuk_indis", 32'(bus.indis_o), N);
        basla();
        chk("basla_ok", 32'(bus.durum_o), 1);
        cekirdek_al(N, 0);
        chk("durum_al", 32'(bus.durum_o), 3);
        yakala(255);
        geri_oku();

        // early start, overflow, backpressure, stray ack
        yukle(10, 100, 1);
        basla();
        chk("erken_durum", 32'(bus.durum_o), 0);
        chk("erken_indis", 32'(bus.indis_o), 10);
        yukle(8, 110, 0);
        for (int i = 0; i < N - 10; i++) q_sun.push_back(8'(110 + i));
        chk("doygun", 32'(bus.indis_o), N);
        basla();
        chk("basla2", 32'(bus.durum_o), 1);
        bus.veri_al_i = 1'b1;
        adim();
        bus.veri_al_i = 1'b0;
        chk("kacak_indis", 32'(bus.indis_o), 0);
        chk("kacak_gec", 32'(bus.veri_gecerli_o), 0);
        cekirdek_al(N, 5);
        chk("durum_al2", 32'(bus.durum_o), 3);
        yakala(200);
        geri_oku();

        // write and start in the same cycle
        yukle(N - 1, 50, 1);
        q_sun.push_back(8'd65);
        bus.yaz_en_i   = 1'b1;
        bus.yaz_veri_i = 8'd65;
        bus.basla_i    = 1'b1;
        adim();
        bus.yaz_en_i = 1'b0;
        chk("es_indis", 32'(bus.indis_o), N);
        chk("es_durum", 32'(bus.durum_o), 0);
        adim();
        bus.basla_i = 1'b0;
        chk("es_basla", 32'(bus.durum_o), 1);
        cekirdek_al(N, 0);
        yakala(90);
        geri_oku();

        // reset mid-stream
        yukle(N, 200, 1);
        basla();
        cekirdek_al(7, 0);
        for (int t = 0; t < 20 && !bus.veri_gecerli_o; t++) adim();
        chk("rs_gec", 32'(bus.veri_gecerli_o), 1);
        chk("rs_indis", 32'(bus.indis_o), 7);
        chk("rs_durum", 32'(bus.durum_o), 2);
        rst_i = 1'b0;
        #1;
        chk("rs_a_durum", 32'(bus.durum_o), 0);
        chk("rs_a_gec", 32'(bus.veri_gecerli_o), 0);
        chk("rs_a_veri", 32'(bus.veri_o), 0);
        chk("rs_a_indis", 32'(bus.indis_o), 0);
        q_sun.delete();
        adim();
        adim();
        rst_i = 1'b1;
        adim();
        basla();
        chk("rs_basla0", 32'(bus.durum_o), 0);
        yukle(N - 1, 30, 1);
        basla();
        chk("rs_basla15", 32'(bus.durum_o), 0);
        yukle(1, 30 + N - 1, 1);
        basla();
        chk("rs_basla16", 32'(bus.durum_o), 1);
        cekirdek_al(N, 0);
        chk("durum_al4", 32'(bus.durum_o), 3);
        adim();
        chk("q_sun_bos", 32'(q_sun.size()), 0);
        chk("q_oku_bos", 32'(q_oku.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
